// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the channel scan sequencer.
// Optional build macro used by the top: SCAN_SEQ_ONEHOT_EN.
package scan_seq_pkg;

  localparam int NCH         = 8;
  localparam int SEL_W       = 3;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Index of the least-significant set bit; 0 when the map is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/dec.sv
// 3-to-8 one-hot channel decoder; only compiled when SCAN_SEQ_ONEHOT_EN is defined.
`ifdef SCAN_SEQ_ONEHOT_EN
module dec (
  input  logic [2:0] in,
  output logic [7:0] out
);

  assign out = 8'b0000_0001 << in;

endmodule
`endif

// File: rtl/scan_seq_next.sv
// Combinational successor search over the latched channel map: next set
// index above sel_i, a wrap flag when none exists, and the lowest set index.
module scan_seq_next
  import scan_seq_pkg::*;
(
  input  logic [NCH-1:0]   mask_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [SEL_W-1:0] next_o,
  output logic             wrap_o,
  output logic [SEL_W-1:0] low_o
);

  always_comb begin
    next_o = '0;
    wrap_o = 1'b1;
    // Walk downward so the closest higher set bit is the one left standing.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(sel_i))) begin
        next_o = SEL_W'(i);
        wrap_o = 1'b0;
      end
    end
  end

  assign low_o = lowest_set(mask_i);

endmodule

// File: rtl/scan_seq.sv
// Channel scan sequencer: steps through the enabled channels of a latched mask,
// holding each for dwell+1 cycles. SCAN_SEQ_ONEHOT_EN adds a decoded onehot output.
module scan_seq
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [NCH-1:0]     mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
`ifdef SCAN_SEQ_ONEHOT_EN
  output logic [NCH-1:0]     onehot,
`endif
  output logic               done
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic               cont_q, cont_d;
  logic               done_q, done_d;

  logic [SEL_W-1:0]   next_sel;
  logic               wrap;
  logic [SEL_W-1:0]   low_sel;

  scan_seq_next u_next (
    .mask_i (mask_q),
    .sel_i  (sel_q),
    .next_o (next_sel),
    .wrap_o (wrap),
    .low_o  (low_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // An empty mask would leave nothing to scan, so such a start is dropped.
        if (start && !stop && (mask != '0)) begin
          mask_d  = mask;
          dwell_d = dwell;
          cont_d  = cont;
          sel_d   = lowest_set(mask);
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (wrap) begin
            done_d = 1'b1;
            if (cont_q) sel_d = low_sel;
            else        state_d = IDLE;
          end else begin
            sel_d = next_sel;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel       = sel_q;
  assign sel_valid = (state_q == HOLD);
  assign done      = done_q;

`ifdef SCAN_SEQ_ONEHOT_EN
  logic [NCH-1:0] dec_out;

  dec u_dec (
    .in  (sel_q),
    .out (dec_out)
  );

  assign onehot = sel_valid ? dec_out : '0;
`endif

endmodule

// File: tb/tb_scan_seq.sv
// Scoreboard bench for scan_seq: each scan pushes its expected per-cycle trace,
// a negedge monitor pops and compares whenever the DUT drives sel_valid or done.
module tb_scan_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [7:0] dwell = 8'h00;
  logic [2:0] sel;
  logic       sel_valid;
  logic       done;
`ifdef SCAN_SEQ_ONEHOT_EN
  logic [7:0] onehot;
`endif

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic       d;
  } exp_t;

  exp_t q[$];

  scan_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .mask      (mask),
    .dwell     (dwell),
    .sel       (sel),
    .sel_valid (sel_valid),
`ifdef SCAN_SEQ_ONEHOT_EN
    .onehot    (onehot),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, int'(sel_valid), 0);
    chk({nm, "_done"}, int'(done), 0);
`ifdef SCAN_SEQ_ONEHOT_EN
    chk({nm, "_onehot"}, int'(onehot), 0);
`endif
  endtask

  // Reference: walk the enabled channels in ascending order, dwell+1 cycles each,
  // repeating when continuous; s != 0 cuts the trace after s output cycles.
  task automatic push_trace(input logic [7:0] m, input int d, input bit c, input int s);
    exp_t e;
    int   t = 1;
    bit   pend = 1'b0;
    bit   fin = 1'b0;
    while (!fin) begin
      for (int ch = 0; ch < 8; ch++) begin
        if (m[ch]) begin
          for (int r = 0; r <= d; r++) begin
            if (!fin) begin
              e.v = 1'b1; e.sel = 3'(ch); e.d = pend;
              pend = 1'b0;
              q.push_back(e);
              if (s != 0 && t == s) fin = 1'b1;
              t++;
            end
          end
        end
      end
      if (!fin) begin
        if (!c) begin
          e.v = 1'b0; e.sel = 3'd0; e.d = 1'b1;
          q.push_back(e);
          fin = 1'b1;
        end else begin
          pend = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n && (sel_valid || done)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: sel_valid=%0b done=%0b sel=%0d, expected no activity",
                 sel_valid, done, sel);
      end else begin
        e = q.pop_front();
        chk("sel_valid", int'(sel_valid), int'(e.v));
        chk("done", int'(done), int'(e.d));
        if (e.v) chk("sel", int'(sel), int'(e.sel));
`ifdef SCAN_SEQ_ONEHOT_EN
        chk("onehot", int'(onehot), e.v ? (1 << e.sel) : 0);
`endif
      end
    end
  end

  // Issue one scan; inputs are scrambled while it runs to show they are latched.
  task automatic run_scan(input logic [7:0] m, input int d, input bit c, input int s);
    int n_on = $countones(m);
    int len = n_on * (d + 1);
    int ncyc = c ? s : ((s != 0) ? s : len + 1);
    int wait_c = 0;
    push_trace(m, d, c, s);
    start = 1'b1; stop = 1'b0; mask = m; dwell = 8'(d); cont = c;
    @(posedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      #1;
      start = (k < ncyc - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop  = (k == s);
      mask  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      dwell = 8'($urandom_range(0, 7));
      cont  = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    #1;
    start = 1'b0; stop = 1'b0;
    while (q.size() != 0 && wait_c < 4) begin
      @(posedge clk);
      #1;
      wait_c++;
    end
    chk("trace_drained_left", q.size(), 0);
    q.delete();
  endtask

  // A start that must not launch a scan.
  task automatic idle_start(input logic [7:0] m, input bit stp);
    start = 1'b1; stop = stp; mask = m; dwell = 8'd1; cont = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_idle(stp ? "start_stop_idle" : "mask0_idle");
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] m;
    int d, s, len;
    bit c;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_sel", int'(sel), 0);
    chk_idle("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("post_reset");
    mon_en = 1'b1;

    run_scan(8'hA4, 2, 1'b0, 0);
    run_scan(8'h81, 0, 1'b1, 9);
    run_scan(8'hA4, 2, 1'b0, 4);
    idle_start(8'hA4, 1'b1);
    idle_start(8'h00, 1'b0);
    run_scan(8'h10, 3, 1'b1, 13);
    run_scan(8'hFF, 0, 1'b0, 0);

    repeat (30) begin
      m = 8'($urandom_range(1, 255));
      d = $urandom_range(0, 4);
      c = 1'($urandom_range(0, 1));
      len = $countones(m) * (d + 1);
      if (c) s = $urandom_range(1, 3 * len + 2);
      else   s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      run_scan(m, d, c, s);
    end

    // Asynchronous reset in the middle of a scan.
    mon_en = 1'b0;
    start = 1'b1; stop = 1'b0; mask = 8'hA4; dwell = 8'd2; cont = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_valid", int'(sel_valid), 1);
    chk("pre_reset_sel", int'(sel), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_sel", int'(sel), 0);
    chk_idle("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk_idle("after_async_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
